// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit:
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - FSM state encoding used by load_store_unit
//   - lane widths used by the alignment logic
//   - bad_alignment(): flags a size/offset pair that cannot be serviced
// No ports (package).
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } lsu_state_e;

  // Reserved size is always rejected; halves need an even address and
  // words need a word-aligned address.
  function automatic logic bad_alignment(input logic [1:0] size,
                                         input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Combinational lane logic for the load/store unit.
//   Loads : extract the addressed byte/half from word and sign/zero extend.
//   Stores: replace only the addressed lane of word with the LSBs of wdata.
// Lanes are little-endian: byte lane = lane[1:0] (lane 0 = bits 7:0),
// half lane = lane[1].
// Ports:
//   size      in  2   request size (lsu_pkg SZ_*)
//   sign_ext  in  1   1 = sign-extend loads, 0 = zero-extend
//   lane      in  2   byte offset within the word
//   word      in  32  word read from memory
//   wdata     in  32  store data, valid bits in LSBs
//   load_data out 32  extended load result
//   merged    out 32  word with the store lane replaced
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [BYTE_W-1:0] sel_byte;
  logic [HALF_W-1:0] sel_half;

  always_comb begin
    sel_byte  = word[{lane, 3'b000} +: BYTE_W];
    sel_half  = word[{lane[1], 4'b0000} +: HALF_W];
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = sign_ext ? {{(WORD_W-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte}
                             : {{(WORD_W-BYTE_W){1'b0}}, sel_byte};
        merged = word;
        merged[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      SZ_HALF: begin
        load_data = sign_ext ? {{(WORD_W-HALF_W){sel_half[HALF_W-1]}}, sel_half}
                             : {{(WORD_W-HALF_W){1'b0}}, sel_half};
        merged = word;
        merged[{lane[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Sequences one load/store request at a time onto a word-only data memory
// with a one-cycle registered read. Byte/half loads are extracted and
// extended; byte/half stores are done as read-modify-write.
//   load          : IDLE -> RD -> CAP -> IDLE
//   word store    : IDLE -> WR -> IDLE
//   sub-word store: IDLE -> RD -> CAP -> WR -> IDLE
//   rejected      : IDLE -> IDLE with resp_err
// resp_valid pulses in the cycle the FSM re-enters IDLE.
// Configuration macro: LSU_BOUNDS_CHECK_EN -- when defined, a byte address
// with any bit set above ADDR_W+1 is rejected; otherwise it wraps.
// Ports:
//   clk, reset                 clock, async active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_signed, req_addr,
//   req_wdata                  request fields, latched on transfer
//   resp_valid, resp_err,
//   resp_rdata                 completion pulse, error flag, load result
//   mem_address, mem_writedata,
//   mem_writeenable, mem_read,
//   mem_data                   data memory interface
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_writeenable,
  output logic        mem_read,
  input  logic [31:0] mem_data
);

  lsu_state_e state, state_next;

  logic              transfer;
  logic              req_bad;
  logic              r_write;
  logic              r_signed;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_widx;
  logic [31:0]       r_wdata;
  logic [31:0]       wr_word;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign transfer = req_valid & req_ready;

`ifdef LSU_BOUNDS_CHECK_EN
  assign req_bad = bad_alignment(req_size, req_addr[1:0]) |
                   (req_addr[31:ADDR_W+2] != '0);
`else
  // Upper address bits are discarded so accesses wrap within memory.
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr[31:ADDR_W+2];
  assign req_bad = bad_alignment(req_size, req_addr[1:0]);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Strobes decode from the state register only, so reset drops them at once.
  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    mem_read        = 1'b0;
    mem_writeenable = 1'b0;
    mem_writedata   = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (transfer && !req_bad) begin
          if (req_write && req_size == SZ_WORD) state_next = ST_WR;
          else                                  state_next = ST_RD;
        end
      end
      ST_RD: begin
        mem_read   = 1'b1;
        state_next = ST_CAP;
      end
      ST_CAP: begin
        state_next = r_write ? ST_WR : ST_IDLE;
      end
      ST_WR: begin
        mem_writeenable = 1'b1;
        mem_writedata   = wr_word;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem_address = {{(32-ADDR_W){1'b0}}, r_widx};

  // mem_data is the registered read result while in CAP.
  lsu_align u_align (
    .size      (r_size),
    .sign_ext  (r_signed),
    .lane      (r_lane),
    .word      (mem_data),
    .wdata     (r_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= SZ_BYTE;
      r_lane     <= 2'b00;
      r_widx     <= '0;
      r_wdata    <= '0;
      wr_word    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_lane   <= req_addr[1:0];
            r_widx   <= req_addr[ADDR_W+1:2];
            r_wdata  <= req_wdata;
            wr_word  <= req_wdata;
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        ST_CAP: begin
          if (r_write) begin
            wr_word <= merged;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        ST_WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit: drives directed and random
// requests, models data memory, and compares every response against a
// byte-arithmetic reference model of memory contents.
// Honours LSU_BOUNDS_CHECK_EN the same way the design does.
module tb_load_store_unit;

  localparam int ADDR_W = 5;
  localparam int NWORDS = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_writeenable;
  logic        mem_read;
  logic [31:0] mem_data;

  logic [31:0] ram     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  int errors = 0;
  int checks = 0;
  int op_num = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_err        (resp_err),
    .resp_rdata      (resp_rdata),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_writeenable (mem_writeenable),
    .mem_read        (mem_read),
    .mem_data        (mem_data)
  );

  // Word-only data memory with a one-cycle registered read.
  always @(posedge clk) begin
    if (mem_writeenable) ram[mem_address[ADDR_W-1:0]] <= mem_writedata;
    if (mem_read)        mem_data <= ram[mem_address[ADDR_W-1:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One request, predicted from byte arithmetic on ref_mem.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz,
                               input logic sg, input logic [31:0] addr,
                               input logic [31:0] wd, input bit known,
                               input logic [31:0] known_rdata);
    int nbytes, widx, sh, lat, n, rd_cnt, wr_cnt, exp_rd, exp_wr;
    bit exp_err, both_hi, hi_bad, seen;
    longint unsigned word, mask, val;
    logic [31:0] exp_rdata;
    string tag;
    op_num++;
    tag = $sformatf("op%0d", op_num);
    case (sz)
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      2'b10:   nbytes = 4;
      default: nbytes = 0;
    endcase
    if (nbytes == 0) exp_err = 1'b1;
    else             exp_err = (addr % nbytes) != 0;
`ifdef LSU_BOUNDS_CHECK_EN
    if ((addr >> (ADDR_W + 2)) != 0) exp_err = 1'b1;
`endif
    widx = int'((addr >> 2) % NWORDS);
    sh   = 8 * int'(addr % 4);
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    exp_rdata = '0;
    if (exp_err) begin
      lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!wr) begin
      word = 64'(ref_mem[widx]);
      val  = (word >> sh) & mask;
      if (sg && val >= (mask + 64'd1) / 2) val = val - (mask + 64'd1);
      exp_rdata = val[31:0];
      lat = 3; exp_rd = 1; exp_wr = 0;
    end else begin
      word = 64'(ref_mem[widx]);
      val  = (word & ~(mask << sh)) | ((64'(wd) & mask) << sh);
      ref_mem[widx] = val[31:0];
      lat    = (nbytes == 4) ? 2 : 4;
      exp_rd = (nbytes == 4) ? 0 : 1;
      exp_wr = 1;
    end

    @(negedge clk);
    checkOutput({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    n = 0; seen = 0; rd_cnt = 0; wr_cnt = 0; both_hi = 0; hi_bad = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      if (mem_read) rd_cnt++;
      if (mem_writeenable) wr_cnt++;
      if (mem_read && mem_writeenable) both_hi = 1;
      if ((mem_read || mem_writeenable) && mem_address[31:ADDR_W] != '0) hi_bad = 1;
      if (resp_valid) seen = 1;
    end
    checkOutput({tag, ".resp_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, ".latency"}, 32'(n), 32'(lat));
    checkOutput({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    checkOutput({tag, ".rdata"}, resp_rdata, exp_rdata);
    if (known) checkOutput({tag, ".rdata_const"}, resp_rdata, known_rdata);
    checkOutput({tag, ".reads"}, 32'(rd_cnt), 32'(exp_rd));
    checkOutput({tag, ".writes"}, 32'(wr_cnt), 32'(exp_wr));
    checkOutput({tag, ".both_strobes"}, 32'(both_hi), 32'd0);
    checkOutput({tag, ".addr_hi"}, 32'(hi_bad), 32'd0);
    checkOutput({tag, ".ready_at_resp"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    checkOutput({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, ".hold"}, resp_rdata, exp_rdata);
    checkOutput({tag, ".mem"}, ram[widx], ref_mem[widx]);
  endtask

  initial begin
    logic        r_wr, r_sg;
    logic [1:0]  r_sz;
    logic [31:0] r_addr, r_wd, fill;
    bit          seen;

    repeat (2) @(negedge clk);
    checkOutput("reset.resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset.resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset.resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset.mem_read", 32'(mem_read), 32'd0);
    checkOutput("reset.mem_we", 32'(mem_writeenable), 32'd0);
    checkOutput("reset.mem_wdata", mem_writedata, 32'd0);
    checkOutput("reset.mem_addr", mem_address, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset.ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < NWORDS; i++) begin
      fill = (i == 12) ? 32'h0000_000F : $urandom;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'(i * 4), fill, 1'b0, '0);
    end

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, '0, 1'b1, 32'h0000_000F);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01, 1'b0, '0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, '0, 1'b1, 32'h0000_007F);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, '0, 1'b1, 32'hFFFF_FF80);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, '0, 1'b1, 32'h0000_80FF);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_56AA, 1'b0, '0);
    checkOutput("spec.byte_merge", ram[4], 32'h80AA_7F01);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h31, '0, 1'b0, '0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h13, '0, 1'b0, '0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h00, '0, 1'b0, '0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h13, 32'hDEAD_BEEF, 1'b0, '0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, '0, 1'b0, '0);

    for (int i = 0; i < 80; i++) begin
      r_wr = 1'($urandom);
      r_sg = 1'($urandom);
      r_sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (r_sz == 2'b01) r_addr[0] = 1'b0;
        if (r_sz == 2'b10) r_addr[1:0] = 2'b00;
      end
      r_wd = $urandom;
      applyStimulus(r_wr, r_sz, r_sg, r_addr, r_wd, 1'b0, '0);
    end

    // Reset while the WR strobe of a word store is active.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = ~ref_mem[8];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst.we_before", 32'(mem_writeenable), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst.we_drop", 32'(mem_writeenable), 32'd0);
    checkOutput("rst.resp_in_reset", 32'(resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    checkOutput("rst.no_resp", 32'(seen), 32'd0);
    checkOutput("rst.ready", 32'(req_ready), 32'd1);
    checkOutput("rst.mem_unchanged", ram[8], ref_mem[8]);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, '0, 1'b0, '0);

    for (int i = 0; i < NWORDS; i++)
      checkOutput($sformatf("final.word%0d", i), ram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
